// File: rtl/acq_trigger_ctrl_pkg.sv
// ----------------------------------------------------------------------------
// acq_pkg
// Shared definitions for the acquisition trigger controller: capture state
// encoding and trigger edge selector values.
// ----------------------------------------------------------------------------
package acq_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_PRE_FILL  = 3'd1,
        ST_WAIT_TRIG = 3'd2,
        ST_POST_FILL = 3'd3,
        ST_DONE      = 3'd4
    } acq_state_t;

    localparam logic EDGE_RISING  = 1'b0;
    localparam logic EDGE_FALLING = 1'b1;

endpackage

// File: rtl/acq_trigger_ctrl_trig_detect.sv
// ----------------------------------------------------------------------------
// trig_detect
// Level-crossing trigger detector. Holds the previously accepted sample and
// the software-force pending latch; compares previous/current samples against
// the threshold for the selected edge.
//
// Ports:
//   clk_i, rst    clock, synchronous active-high reset
//   clear_hist    forget the previous sample (new capture / abort)
//   sample_en     an accepted sample is being consumed this cycle
//   cur           current sample
//   level         trigger threshold (unsigned)
//   trig_edge     0 = rising, 1 = falling
//   force_set     set the force-pending latch
//   pending_clr   clear the force-pending latch (has priority over set)
//   hit           current sample forms a crossing with the previous one
//   pending       a forced trigger is waiting for the next accepted sample
// ----------------------------------------------------------------------------
module trig_detect
    import acq_pkg::*;
#(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk_i,
    input  logic                  rst,
    input  logic                  clear_hist,
    input  logic                  sample_en,
    input  logic [DATA_WIDTH-1:0] cur,
    input  logic [DATA_WIDTH-1:0] level,
    input  logic                  trig_edge,
    input  logic                  force_set,
    input  logic                  pending_clr,
    output logic                  hit,
    output logic                  pending
);

    logic [DATA_WIDTH-1:0] prev;
    logic                  prev_valid;

    always_ff @(posedge clk_i) begin
        if (rst) begin
            prev       <= '0;
            prev_valid <= 1'b0;
        end else if (clear_hist) begin
            prev_valid <= 1'b0;
        end else if (sample_en) begin
            prev       <= cur;
            prev_valid <= 1'b1;
        end
    end

    // A force registered this cycle only affects samples accepted later.
    always_ff @(posedge clk_i) begin
        if (rst) begin
            pending <= 1'b0;
        end else if (pending_clr) begin
            pending <= 1'b0;
        end else if (force_set) begin
            pending <= 1'b1;
        end
    end

    always_comb begin
        hit = 1'b0;
        if (prev_valid) begin
            if (trig_edge == EDGE_RISING) begin
                hit = (prev < level) && (cur >= level);
            end else begin
                hit = (prev > level) && (cur <= level);
            end
        end
    end

endmodule

// File: rtl/acq_trigger_ctrl.sv
// ----------------------------------------------------------------------------
// acq_trigger_ctrl
// Acquisition sequencer between the ADC simple-interface stream and the
// channel sample memory. Fills a pre-trigger window, waits for a level
// crossing or a software force, fills the post-trigger window, writing all
// samples into a circular buffer.
//
// Ports:
//   clk_i, rst                 clock, synchronous active-high reset
//   SI_data/SI_rdy/SI_ack      ADC sample stream (never stalled)
//   start/stop/force_trig      one-cycle host control pulses
//   trig_level/trig_edge       trigger threshold and edge select
//   num_samples/pretrig_count  capture size and pre-trigger depth
//   buf_we/buf_addr/buf_wdata  sample buffer write port (1-cycle latency)
//   busy/triggered/done        capture status
//   trig_addr/start_addr       trigger sample address, first valid sample
// ----------------------------------------------------------------------------
module acq_trigger_ctrl
    import acq_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 12
) (
    input  logic                  clk_i,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] SI_data,
    input  logic                  SI_rdy,
    output logic                  SI_ack,
    input  logic                  start,
    input  logic                  stop,
    input  logic                  force_trig,
    input  logic [DATA_WIDTH-1:0] trig_level,
    input  logic                  trig_edge,
    input  logic [ADDR_WIDTH:0]   num_samples,
    input  logic [ADDR_WIDTH:0]   pretrig_count,
    output logic                  buf_we,
    output logic [ADDR_WIDTH-1:0] buf_addr,
    output logic [DATA_WIDTH-1:0] buf_wdata,
    output logic                  busy,
    output logic                  triggered,
    output logic                  done,
    output logic [ADDR_WIDTH-1:0] trig_addr,
    output logic [ADDR_WIDTH-1:0] start_addr
);

    acq_state_t            state;
    acq_state_t            state_nxt;
    logic                  accept;
    logic                  in_capture;
    logic                  start_go;
    logic                  sample_go;
    logic                  trig_fire;
    logic                  trig_hit;
    logic                  trig_pending;
    logic [ADDR_WIDTH:0]   num_eff;
    logic [ADDR_WIDTH:0]   pre_eff;
    logic [ADDR_WIDTH:0]   num_lat;
    logic [ADDR_WIDTH:0]   pre_lat;
    logic [ADDR_WIDTH:0]   post_target;
    logic [ADDR_WIDTH:0]   cnt;
    logic [ADDR_WIDTH:0]   cnt_inc;
    logic [ADDR_WIDTH-1:0] wptr;

    assign SI_ack     = SI_rdy;
    assign accept     = SI_rdy & SI_ack;
    assign in_capture = (state == ST_PRE_FILL) || (state == ST_WAIT_TRIG) ||
                        (state == ST_POST_FILL);
    assign start_go   = start && !stop && ((state == ST_IDLE) || (state == ST_DONE));
    assign sample_go  = accept && !stop && in_capture;
    assign trig_fire  = sample_go && (state == ST_WAIT_TRIG) && (trig_hit || trig_pending);
    assign cnt_inc    = cnt + 1'b1;
    assign post_target = num_lat - pre_lat;
    assign busy       = in_capture;
    assign done       = (state == ST_DONE);

    // Zero samples means one; the pre window must leave room for the trigger sample.
    always_comb begin
        num_eff = (num_samples == '0) ? {{ADDR_WIDTH{1'b0}}, 1'b1} : num_samples;
        pre_eff = (pretrig_count >= num_eff) ? (num_eff - 1'b1) : pretrig_count;
    end

    trig_detect #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_trig_detect (
        .clk_i       (clk_i),
        .rst         (rst),
        .clear_hist  (start_go || stop),
        .sample_en   (sample_go),
        .cur         (SI_data),
        .level       (trig_level),
        .trig_edge   (trig_edge),
        .force_set   (force_trig && (state == ST_WAIT_TRIG)),
        .pending_clr (stop || (state != ST_WAIT_TRIG) || trig_fire),
        .hit         (trig_hit),
        .pending     (trig_pending)
    );

    always_ff @(posedge clk_i) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        if (stop) begin
            state_nxt = ST_IDLE;
        end else begin
            case (state)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        state_nxt = (pre_eff == '0) ? ST_WAIT_TRIG : ST_PRE_FILL;
                    end
                end
                ST_PRE_FILL: begin
                    if (sample_go && (cnt_inc == pre_lat)) begin
                        state_nxt = ST_WAIT_TRIG;
                    end
                end
                ST_WAIT_TRIG: begin
                    if (trig_fire) begin
                        state_nxt = (post_target == {{ADDR_WIDTH{1'b0}}, 1'b1}) ?
                                    ST_DONE : ST_POST_FILL;
                    end
                end
                ST_POST_FILL: begin
                    if (sample_go && (cnt_inc == post_target)) begin
                        state_nxt = ST_DONE;
                    end
                end
                default: state_nxt = ST_IDLE;
            endcase
        end
    end

    // Write port, pointers, counters and capture results. The counter serves
    // as the pre-fill count and, after the trigger, as the post-fill count.
    always_ff @(posedge clk_i) begin
        if (rst) begin
            buf_we     <= 1'b0;
            buf_addr   <= '0;
            buf_wdata  <= '0;
            wptr       <= '0;
            cnt        <= '0;
            num_lat    <= '0;
            pre_lat    <= '0;
            triggered  <= 1'b0;
            trig_addr  <= '0;
            start_addr <= '0;
        end else begin
            buf_we <= sample_go;
            if (sample_go) begin
                buf_addr  <= wptr;
                buf_wdata <= SI_data;
            end
            if (stop) begin
                triggered <= 1'b0;
            end else if (start_go) begin
                num_lat   <= num_eff;
                pre_lat   <= pre_eff;
                wptr      <= '0;
                cnt       <= '0;
                triggered <= 1'b0;
            end else if (sample_go) begin
                wptr <= wptr + 1'b1;
                if (trig_fire) begin
                    trig_addr  <= wptr;
                    start_addr <= wptr - pre_lat[ADDR_WIDTH-1:0];
                    triggered  <= 1'b1;
                    cnt        <= {{ADDR_WIDTH{1'b0}}, 1'b1};
                end else begin
                    cnt <= cnt_inc;
                end
            end
        end
    end

endmodule
